mem_access: RTL and testbench

- Memory-access stage directly downstream of the execute stage.
- Consumes the ALU result as the effective address and the second register operand as store data.
- Performs byte/halfword/word loads and stores over a req/ack data-memory handshake, with sign/zero extension and byte-lane alignment.
- Stalls upstream while a transfer is outstanding, and passes non-memory ALU results through to writeback.

---
 rtl/mem_access_pkg.sv | 40 ++++
 rtl/mem_access_if.sv | 21 ++
 rtl/mem_align.sv | 50 +++++
 rtl/mem_access.sv | 160 ++++++++++++++++
 tb/tb_mem_access.sv | 396 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_pkg.sv
// mem_access shared types and constants.
// Size/state encodings, byte-enable bases, legality check.
package mem_access_pkg;

    typedef enum logic [1:0] {
        MS_BYTE = 2'b00,
        MS_HALF = 2'b01,
        MS_WORD = 2'b10,
        MS_ILL  = 2'b11
    } msize_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // True when a memory op cannot be issued to the bus.
    function automatic logic acc_illegal(
        input msize_e     size,
        input logic [1:0] lo,
        input logic       rd,
        input logic       wr
    );
        logic bad;
        bad = rd & wr;
        case (size)
            MS_HALF: bad = bad | lo[0];
            MS_WORD: bad = bad | (lo != 2'b00);
            MS_ILL:  bad = 1'b1;
            default: bad = bad;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory req/ack bus.
// master = memory stage, slave = memory.
interface mem_access_if;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    modport master (
        output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        input  dm_ack, dm_rdata
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        output dm_ack, dm_rdata
    );
endinterface

// File: rtl/mem_align.sv
// Byte-lane steering for stores and lane
// extraction plus sign/zero extension for loads.
module mem_align
    import mem_access_pkg::*;
(
    input  msize_e      size_i,
    input  logic        sign_i,
    input  logic [1:0]  lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Select the addressed byte and halfword of the read word.
    always_comb begin
        lane_b = 8'h00;
        unique case (lo_i)
            2'd0: lane_b = rdata_i[7:0];
            2'd1: lane_b = rdata_i[15:8];
            2'd2: lane_b = rdata_i[23:16];
            2'd3: lane_b = rdata_i[31:24];
        endcase
        lane_h = lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    // Enables, replicated store data and extended load value.
    always_comb begin
        be_o    = 4'b0000;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
        case (size_i)
            MS_BYTE: begin
                be_o    = BE_BYTE << lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{sign_i & lane_b[7]}}, lane_b};
            end
            MS_HALF: begin
                be_o    = BE_HALF << lo_i;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{sign_i & lane_h[15]}}, lane_h};
            end
            MS_WORD: be_o = BE_WORD;
            default: be_o = 4'b0000;
        endcase
    end
endmodule

// File: rtl/mem_access.sv
// Memory-access stage: loads/stores over a req/ack
// bus, ALU pass-through, stall and error reporting.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        Alu_result,
    input  logic [31:0]        Read_data_2,
    input  logic               MemRead,
    input  logic               MemWrite,
    input  logic [1:0]         MemSize,
    input  logic               MemSigned,
    mem_access_if.master       dm,
    output logic               out_valid,
    output logic [31:0]        Mem_result,
    output logic               Mem_stall,
    output logic               Addr_err,
    output logic               Bus_err
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    msize_e           size_q;
    logic             sign_q;
    logic [1:0]       lo_q;
    logic             dm_req_q;
    logic             dm_we_q;
    logic [31:0]      dm_addr_q;
    logic [3:0]       dm_be_q;
    logic [31:0]      dm_wdata_q;
    logic             out_valid_q;
    logic [31:0]      mem_result_q;
    logic             addr_err_q;
    logic             bus_err_q;

    msize_e      in_size;
    logic        is_mem;
    logic        acc_err;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] st_rdata_unused;
    logic [3:0]  ld_be_unused;
    logic [31:0] ld_wdata_unused;
    logic [31:0] ld_data;

    assign in_size = msize_e'(MemSize);
    assign is_mem  = MemRead | MemWrite;
    assign acc_err = acc_illegal(in_size, Alu_result[1:0],
                                 MemRead, MemWrite);

    // Store path: steer the incoming operand at accept.
    mem_align u_st_align (
        .size_i  (in_size),
        .sign_i  (MemSigned),
        .lo_i    (Alu_result[1:0]),
        .wdata_i (Read_data_2),
        .rdata_i (32'h0),
        .be_o    (st_be),
        .wdata_o (st_wdata),
        .rdata_o (st_rdata_unused)
    );

    // Load path: extract from the returned word at ack.
    mem_align u_ld_align (
        .size_i  (size_q),
        .sign_i  (sign_q),
        .lo_i    (lo_q),
        .wdata_i (32'h0),
        .rdata_i (dm.dm_rdata),
        .be_o    (ld_be_unused),
        .wdata_o (ld_wdata_unused),
        .rdata_o (ld_data)
    );

    // Stage FSM with registered bus and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            size_q       <= MS_BYTE;
            sign_q       <= 1'b0;
            lo_q         <= 2'b00;
            dm_req_q     <= 1'b0;
            dm_we_q      <= 1'b0;
            dm_addr_q    <= '0;
            dm_be_q      <= '0;
            dm_wdata_q   <= '0;
            out_valid_q  <= 1'b0;
            mem_result_q <= '0;
            addr_err_q   <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            addr_err_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (!is_mem) begin
                            out_valid_q  <= 1'b1;
                            mem_result_q <= Alu_result;
                        end else if (acc_err) begin
                            out_valid_q  <= 1'b1;
                            addr_err_q   <= 1'b1;
                            mem_result_q <= '0;
                        end else begin
                            dm_req_q   <= 1'b1;
                            dm_we_q    <= MemWrite;
                            dm_addr_q  <= {Alu_result[31:2], 2'b00};
                            dm_be_q    <= st_be;
                            dm_wdata_q <= st_wdata;
                            size_q     <= in_size;
                            sign_q     <= MemSigned;
                            lo_q       <= Alu_result[1:0];
                            cnt_q      <= '0;
                            state_q    <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (dm.dm_ack) begin
                        dm_req_q     <= 1'b0;
                        out_valid_q  <= 1'b1;
                        mem_result_q <= dm_we_q ? '0 : ld_data;
                        state_q      <= ST_RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        dm_req_q     <= 1'b0;
                        out_valid_q  <= 1'b1;
                        bus_err_q    <= 1'b1;
                        mem_result_q <= '0;
                        state_q      <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign Mem_stall   = ~in_ready;
    assign out_valid   = out_valid_q;
    assign Mem_result  = mem_result_q;
    assign Addr_err    = addr_err_q;
    assign Bus_err     = bus_err_q;
    assign dm.dm_req   = dm_req_q;
    assign dm.dm_we    = dm_we_q;
    assign dm.dm_addr  = dm_addr_q;
    assign dm.dm_be    = dm_be_q;
    assign dm.dm_wdata = dm_wdata_q;
endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: transaction model with a
// per-cycle compare process plus directed literals.
module tb_mem_access;
    localparam int MAX_WAIT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] Alu_result = '0;
    logic [31:0] Read_data_2 = '0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [1:0]  MemSize = 2'b00;
    logic        MemSigned = 1'b0;
    logic        out_valid;
    logic [31:0] Mem_result;
    logic        Mem_stall;
    logic        Addr_err;
    logic        Bus_err;

    mem_access_if dm_bus ();

    mem_access #(.MAX_WAIT(MAX_WAIT), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .Alu_result  (Alu_result),
        .Read_data_2 (Read_data_2),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemSize     (MemSize),
        .MemSigned   (MemSigned),
        .dm          (dm_bus),
        .out_valid   (out_valid),
        .Mem_result  (Mem_result),
        .Mem_stall   (Mem_stall),
        .Addr_err    (Addr_err),
        .Bus_err     (Bus_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h",
                     nm, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic m_illegal(input logic rd,
        input logic wr, input int size, input logic [31:0] a);
        return (rd && wr) || size == 3 ||
               (size == 1 && a[0]) ||
               (size == 2 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [3:0] m_be(input int size,
                                        input logic [31:0] a);
        int sh;
        sh = int'(a[1:0]);
        if (size == 0) return 4'(1 << sh);
        if (size == 1) return 4'(3 << sh);
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input int size,
                                            input logic [31:0] d);
        if (size == 0) return {24'h0, d[7:0]} * 32'h0101_0101;
        if (size == 1) return {16'h0, d[15:0]} * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input int size,
        input logic sgn, input logic [31:0] a,
        input logic [31:0] rd);
        logic [31:0] v;
        if (size == 2) return rd;
        if (size == 0) begin
            v = (rd >> (8 * int'(a[1:0]))) & 32'hFF;
            if (sgn && v >= 32'd128) v = v - 32'd256;
        end else begin
            v = (rd >> (16 * int'(a[1]))) & 32'hFFFF;
            if (sgn && v >= 32'd32768) v = v - 32'd65536;
        end
        return v;
    endfunction

    typedef struct {
        logic [31:0] res;
        logic        aerr;
        logic        berr;
    } exp_t;

    exp_t expq[$];
    exp_t ce;

    bit          xb_on = 1'b0;
    logic [31:0] xb_addr = '0;
    logic [31:0] xb_wdata = '0;
    logic [3:0]  xb_be = '0;
    logic        xb_we = 1'b0;

    // ---------------- memory responder ----------------
    int          mem_wait = 0;
    bit          mem_ack_en = 1'b1;
    logic [31:0] mem_rdata = '0;
    int          req_age = 0;

    always @(negedge clk) begin
        if (dm_bus.dm_req) begin
            if (mem_ack_en && req_age == mem_wait) begin
                dm_bus.dm_ack   = 1'b1;
                dm_bus.dm_rdata = mem_rdata;
            end else begin
                dm_bus.dm_ack   = 1'b0;
                dm_bus.dm_rdata = 32'h5A5A_5A5A;
            end
            req_age++;
        end else begin
            req_age         = 0;
            dm_bus.dm_ack   = 1'b0;
            dm_bus.dm_rdata = 32'hA5A5_A5A5;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            chk("stall_vs_ready", 32'(Mem_stall),
                32'(!in_ready));
            if (dm_bus.dm_req) begin
                if (!xb_on) begin
                    chk("dm_req_unexpected",
                        32'(dm_bus.dm_req), 32'd0);
                end else begin
                    chk("dm_addr", dm_bus.dm_addr, xb_addr);
                    chk("dm_be", 32'(dm_bus.dm_be), 32'(xb_be));
                    chk("dm_we", 32'(dm_bus.dm_we), 32'(xb_we));
                    if (xb_we)
                        chk("dm_wdata", dm_bus.dm_wdata, xb_wdata);
                end
            end
            if (out_valid) begin
                if (expq.size() == 0) begin
                    chk("spurious_out_valid",
                        32'(out_valid), 32'd0);
                end else begin
                    ce = expq.pop_front();
                    chk("Mem_result", Mem_result, ce.res);
                    chk("Addr_err", 32'(Addr_err), 32'(ce.aerr));
                    chk("Bus_err", 32'(Bus_err), 32'(ce.berr));
                end
            end else begin
                chk("err_without_valid",
                    32'({Addr_err, Bus_err}), 32'd0);
            end
        end
    end

    // ---------------- transaction driver ----------------
    int          r_lat, r_reqc;
    logic [31:0] r_res, r_addr0, r_wd0;
    logic        r_aerr, r_berr, r_we0;
    logic [3:0]  r_be0;
    bit          r_stall;

    task automatic issue(input string nm, input logic rd,
        input logic wr, input logic [1:0] size,
        input logic sgn, input logic [31:0] addr,
        input logic [31:0] wd, input logic [31:0] rdat,
        input int waitn, input bit acken);
        exp_t e;
        bit   ill, nomem, tmo;
        int   xreq, xlat, guard;
        nomem = !rd && !wr;
        ill   = !nomem && m_illegal(rd, wr, int'(size), addr);
        tmo   = !acken || waitn > MAX_WAIT - 1;
        if (nomem)    e = '{addr, 1'b0, 1'b0};
        else if (ill) e = '{32'h0, 1'b1, 1'b0};
        else if (tmo) e = '{32'h0, 1'b0, 1'b1};
        else e = '{wr ? 32'h0 :
                   m_load(int'(size), sgn, addr, rdat),
                   1'b0, 1'b0};
        xreq = (nomem || ill) ? 0 :
               (tmo ? MAX_WAIT : waitn + 1);
        xlat = (nomem || ill) ? 1 : xreq + 1;
        mem_wait   = waitn;
        mem_ack_en = acken;
        mem_rdata  = rdat;
        xb_addr    = {addr[31:2], 2'b00};
        xb_be      = m_be(int'(size), addr);
        xb_we      = wr;
        xb_wdata   = m_wdata(int'(size), wd);
        xb_on      = !(nomem || ill);
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        chk({nm, "_ready"}, 32'(in_ready), 32'd1);
        expq.push_back(e);
        in_valid    = 1'b1;
        MemRead     = rd;
        MemWrite    = wr;
        MemSize     = size;
        MemSigned   = sgn;
        Alu_result  = addr;
        Read_data_2 = wd;
        @(posedge clk); #1;
        in_valid = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        r_lat = 0; r_reqc = 0; r_stall = 1'b1;
        r_addr0 = '0; r_wd0 = '0; r_be0 = '0; r_we0 = 1'b0;
        while (r_lat < 100) begin
            @(negedge clk);
            r_lat++;
            if (dm_bus.dm_req) begin
                if (r_reqc == 0) begin
                    r_addr0 = dm_bus.dm_addr;
                    r_be0   = dm_bus.dm_be;
                    r_we0   = dm_bus.dm_we;
                    r_wd0   = dm_bus.dm_wdata;
                end
                r_reqc++;
            end
            r_stall = r_stall && Mem_stall;
            if (out_valid) break;
        end
        r_res  = Mem_result;
        r_aerr = Addr_err;
        r_berr = Bus_err;
        chk({nm, "_latency"}, 32'(r_lat), 32'(xlat));
        chk({nm, "_req_cycles"}, 32'(r_reqc), 32'(xreq));
        xb_on = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        #12;
        chk("rst_dm_req", 32'(dm_bus.dm_req), 32'd0);
        chk("rst_dm_we", 32'(dm_bus.dm_we), 32'd0);
        chk("rst_dm_be", 32'(dm_bus.dm_be), 32'd0);
        chk("rst_dm_addr", dm_bus.dm_addr, 32'd0);
        chk("rst_dm_wdata", dm_bus.dm_wdata, 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_Mem_result", Mem_result, 32'd0);
        chk("rst_errs", 32'({Addr_err, Bus_err}), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // three back-to-back pass-through accepts
        in_valid   = 1'b1;
        Alu_result = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            expq.push_back('{32'h1234_5678, 1'b0, 1'b0});
            @(posedge clk);
            @(negedge clk);
            chk("pass_out_valid", 32'(out_valid), 32'd1);
            chk("pass_result", Mem_result, 32'h1234_5678);
            chk("pass_no_req", 32'(dm_bus.dm_req), 32'd0);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("pass_done", 32'(out_valid), 32'd0);

        issue("lb_s", 1, 0, 2'b00, 1, 32'h0000_0103, 0,
              32'h80FF_0000, 0, 1);
        chk("lb_s_addr", r_addr0, 32'h0000_0100);
        chk("lb_s_be", 32'(r_be0), 32'h8);
        chk("lb_s_res", r_res, 32'hFFFF_FF80);
        chk("lb_s_lat", 32'(r_lat), 32'd2);

        issue("lbu", 1, 0, 2'b00, 0, 32'h0000_0103, 0,
              32'h80FF_0000, 0, 1);
        chk("lbu_res", r_res, 32'h0000_0080);

        issue("sh", 0, 1, 2'b01, 0, 32'h0000_0202,
              32'hAAAA_BEEF, 0, 3, 1);
        chk("sh_we", 32'(r_we0), 32'd1);
        chk("sh_be", 32'(r_be0), 32'hC);
        chk("sh_wdata", r_wd0, 32'hBEEF_BEEF);
        chk("sh_held", 32'(r_reqc), 32'd4);
        chk("sh_lat", 32'(r_lat), 32'd5);
        chk("sh_res", r_res, 32'd0);

        issue("lw_mis", 1, 0, 2'b10, 0, 32'h0000_0006, 0,
              0, 0, 1);
        chk("lw_mis_aerr", 32'(r_aerr), 32'd1);
        chk("lw_mis_lat", 32'(r_lat), 32'd1);
        chk("lw_mis_res", r_res, 32'd0);

        issue("tmo", 1, 0, 2'b10, 0, 32'h0000_0010, 0,
              32'hFFFF_FFFF, 0, 0);
        chk("tmo_req", 32'(r_reqc), 32'd16);
        chk("tmo_berr", 32'(r_berr), 32'd1);
        chk("tmo_stall", 32'(r_stall), 32'd1);
        @(negedge clk);
        chk("tmo_ready_back", 32'(in_ready), 32'd1);
        chk("tmo_single_pulse", 32'(out_valid), 32'd0);

        issue("ack_last", 1, 0, 2'b10, 0, 32'h0000_0020, 0,
              32'h1357_9BDF, MAX_WAIT - 1, 1);
        chk("ack_last_berr", 32'(r_berr), 32'd0);
        chk("ack_last_res", r_res, 32'h1357_9BDF);

        issue("lh_s", 1, 0, 2'b01, 1, 32'h0000_0002, 0,
              32'h8001_1234, 0, 1);
        chk("lh_s_res", r_res, 32'hFFFF_8001);
        issue("lhu", 1, 0, 2'b01, 0, 32'h0000_0002, 0,
              32'h8001_1234, 2, 1);
        issue("sb", 0, 1, 2'b00, 0, 32'h0000_0301,
              32'h1234_5678, 0, 1, 1);
        chk("sb_be", 32'(r_be0), 32'h2);
        chk("sb_wdata", r_wd0, 32'h7878_7878);
        issue("sw", 0, 1, 2'b10, 1, 32'h0000_0400,
              32'hDEAD_BEEF, 0, 2, 1);
        issue("lw", 1, 0, 2'b10, 1, 32'h0000_0404, 0,
              32'hCAFE_F00D, 0, 1);
        chk("lw_res", r_res, 32'hCAFE_F00D);
        issue("lbu0", 1, 0, 2'b00, 0, 32'h0000_0000, 0,
              32'h1122_337F, 1, 1);
        issue("size11", 1, 0, 2'b11, 0, 32'h0000_0008, 0,
              0, 0, 1);
        issue("rd_wr", 1, 1, 2'b10, 0, 32'h0000_0008, 0,
              0, 0, 1);
        issue("lh_mis", 1, 0, 2'b01, 1, 32'h0000_0005, 0,
              0, 0, 1);
        chk("lh_mis_aerr", 32'(r_aerr), 32'd1);

        // reset while the request is outstanding
        mem_ack_en = 1'b0;
        xb_addr = 32'h0000_0500;
        xb_be   = 4'hF;
        xb_we   = 1'b0;
        xb_on   = 1'b1;
        @(posedge clk); #1;
        in_valid   = 1'b1;
        MemRead    = 1'b1;
        MemSize    = 2'b10;
        Alu_result = 32'h0000_0500;
        @(posedge clk); #1;
        in_valid = 1'b0;
        MemRead  = 1'b0;
        @(negedge clk);
        chk("rstw_req1", 32'(dm_bus.dm_req), 32'd1);
        @(negedge clk);
        chk("rstw_req2", 32'(dm_bus.dm_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstw_async_req", 32'(dm_bus.dm_req), 32'd0);
        chk("rstw_ready", 32'(in_ready), 32'd1);
        xb_on = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        mem_ack_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rstw_no_valid", 32'(out_valid), 32'd0);
            chk("rstw_idle", 32'(in_ready), 32'd1);
        end

        issue("post_rst", 1, 0, 2'b10, 0, 32'h0000_0600, 0,
              32'h0BAD_F00D, 0, 1);
        chk("post_rst_res", r_res, 32'h0BAD_F00D);

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(expq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
